// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Owns the program counter, drives the IMEM read
// address combinationally from it, and captures the returned word into an
// IF/ID register handed to decode through a valid/ready handshake. Later
// stages can redirect the PC (jump/branch); a redirect flushes the IF/ID
// register and costs one bubble cycle.
//
// Optional feature (compile-time macro FETCH_EARLY_JUMP_EN):
//   When defined, a J-type word (opcode 6'b000010) captured into IF/ID also
//   steers the PC to its target on the same edge, so no bubble is paid. The
//   jump is still forwarded downstream. An external redirect overrides it.
//   When undefined, fetch is purely sequential (pc+4) apart from redirects.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   IMEM_WORDS  IMEM depth in 32-bit words, used for the out-of-range flag
//
// Ports
//   clk            in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-high reset
//   imem_addr      out  32  byte address to IMEM (= pc)
//   imem_instr     in   32  instruction word from IMEM (same-cycle read)
//   redirect_valid in   1   later stage requests a PC change this cycle
//   redirect_pc    in   32  redirect target byte address
//   out_valid      out  1   IF/ID register holds a valid instruction
//   out_ready      in   1   decode accepts IF/ID contents this cycle
//   out_instr      out  32  fetched instruction
//   out_pc         out  32  byte address of out_instr
//   out_pc_plus4   out  32  out_pc + 4
//   fetch_count    out  32  instructions handed off, wraps mod 2^32
//   misalign_err   out  1   sticky: a redirect target had nonzero bits [1:0]
//   pc_oob         out  1   sticky: a pc >= 4*IMEM_WORDS was fetched
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        misalign_err,
    output logic        pc_oob
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc_plus4;
    logic [31:0] r_fetch_count;
    logic        r_misalign_err;
    logic        r_pc_oob;

    logic        w_load;
    logic        w_handoff;
    logic        w_oob;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic [31:0] w_redirect_pc;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here, unconditionally first) so no latch is inferred.
    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_next_pc     = w_pc_plus4;
        w_redirect_pc = redirect_pc & ~32'h3;
        // IF/ID may be (re)filled when it is empty or being drained; BOOT never fills.
        w_load        = (r_state != ST_BOOT) && (!r_out_valid || out_ready);
        w_handoff     = r_out_valid && out_ready;
        w_oob         = ({2'b00, r_pc[31:2]} >= IMEM_LIMIT);
`ifdef FETCH_EARLY_JUMP_EN
        if (imem_instr[31:26] == 6'b000010) begin
            w_next_pc = {w_pc_plus4[31:28], imem_instr[25:0], 2'b00};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_out_valid    <= 1'b0;
            r_out_instr    <= 32'h0;
            r_out_pc       <= 32'h0;
            r_out_pc_plus4 <= 32'h0;
            r_fetch_count  <= 32'h0;
            r_misalign_err <= 1'b0;
            r_pc_oob       <= 1'b0;
        end else begin
            // A handoff in the same cycle as a redirect still counts.
            if (w_handoff) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end

            if (r_state == ST_BOOT) begin
                // One settling cycle with no capture; an early redirect is kept.
                if (redirect_valid) begin
                    r_pc <= w_redirect_pc;
                end
                r_state <= ST_RUN;
            end else if (redirect_valid) begin
                r_pc        <= w_redirect_pc;
                r_out_valid <= 1'b0;
                r_state     <= ST_RUN;
            end else if (w_load) begin
                r_out_instr    <= imem_instr;
                r_out_pc       <= r_pc;
                r_out_pc_plus4 <= w_pc_plus4;
                r_out_valid    <= 1'b1;
                r_pc           <= w_next_pc;
                r_state        <= ST_RUN;
                // IMEM aliases, so fetch proceeds; the flag only records it.
                if (w_oob) begin
                    r_pc_oob <= 1'b1;
                end
            end else begin
                // Valid word stalled by decode: freeze pc and IF/ID.
                r_state <= ST_HOLD;
            end
        end
    end

    assign imem_addr    = r_pc;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_pc_plus4 = r_out_pc_plus4;
    assign fetch_count  = r_fetch_count;
    assign misalign_err = r_misalign_err;
    assign pc_oob       = r_pc_oob;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] fetch_count;
    logic        misalign_err;
    logic        pc_oob;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] JUMP_WORD = 32'h0800_0400;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (1024)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err),
        .pc_oob         (pc_oob)
    );

    always #5 clk = ~clk;

    // Program: a J-type word at byte 84, otherwise non-jump words tagged by address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'd84) return JUMP_WORD;
        return 32'hAB00_0000 | {16'h0000, a[15:0]};
    endfunction

    assign imem_instr = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        step();
        reset = 1'b0;
        repeat (5) step();

        // ---- 1: reset mid-run, then BOOT cycle, then pc 0,4,8 stream
        #2 reset = 1'b1;
        #1;
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_flags", {30'd0, misalign_err, pc_oob}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("boot_no_capture", 32'(out_valid), 32'd0);
        check("boot_imem_addr", imem_addr, 32'd0);
        step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, 32'd0);
        check("first_instr", out_instr, 32'hAB00_0000);
        check("first_pc_plus4", out_pc_plus4, 32'd4);
        step();
        check("seq_pc4", out_pc, 32'd4);
        check("seq_count1", fetch_count, 32'd1);
        step();
        check("seq_pc8", out_pc, 32'd8);
        check("seq_imem12", imem_addr, 32'd12);

        // ---- 2: stall three cycles with out_pc=8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_pc", out_pc, 32'd8);
            check("hold_instr", out_instr, 32'hAB00_0008);
            check("hold_imem", imem_addr, 32'd12);
            check("hold_count", fetch_count, 32'd2);
        end
        out_ready = 1'b1;
        step();
        check("release_pc12", out_pc, 32'd12);
        check("release_count", fetch_count, 32'd3);
        step();
        step();
        check("pc20", out_pc, 32'd20);
        check("count5", fetch_count, 32'd5);

        // ---- 3: redirect to 88 while out_pc=20
        redirect_valid = 1'b1;
        redirect_pc    = 32'd88;
        step();
        redirect_valid = 1'b0;
        check("redir_bubble", 32'(out_valid), 32'd0);
        check("redir_imem", imem_addr, 32'd88);
        check("redir_handoff_counted", fetch_count, 32'd6);
        step();
        check("redir_out_pc", out_pc, 32'd88);
        check("redir_valid_back", 32'(out_valid), 32'd1);

        // ---- 4: misaligned redirect, then a clean one
        redirect_valid = 1'b1;
        redirect_pc    = 32'h59;
        step();
        check("misalign_imem", imem_addr, 32'h58);
        check("misalign_set", 32'(misalign_err), 32'd1);
        check("misalign_count", fetch_count, 32'd7);
        redirect_pc = 32'd84;
        step();
        redirect_valid = 1'b0;
        check("misalign_sticky", 32'(misalign_err), 32'd1);
        check("redir84_imem", imem_addr, 32'd84);

        // ---- 5/6: jump word at 84
        step();
        check("jump_out_pc", out_pc, 32'd84);
        check("jump_out_instr", out_instr, JUMP_WORD);
        check("jump_valid", 32'(out_valid), 32'd1);
        check("jump_no_oob", 32'(pc_oob), 32'd0);
`ifdef FETCH_EARLY_JUMP_EN
        check("early_jump_imem", imem_addr, 32'd4096);
        step();
        check("early_jump_out_pc", out_pc, 32'd4096);
        check("early_jump_oob", 32'(pc_oob), 32'd1);
        check("early_jump_count", fetch_count, 32'd8);
`else
        check("seq_after_jump_imem", imem_addr, 32'd88);
        step();
        check("seq_after_jump_pc", out_pc, 32'd88);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd4096;
        step();
        redirect_valid = 1'b0;
        check("late_jump_bubble", 32'(out_valid), 32'd0);
        check("late_jump_no_oob_yet", 32'(pc_oob), 32'd0);
        step();
        check("late_jump_out_pc", out_pc, 32'd4096);
        check("late_jump_oob", 32'(pc_oob), 32'd1);
        check("late_jump_count", fetch_count, 32'd9);
`endif

        // ---- pc wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", out_pc_plus4, 32'd0);
        check("wrap_imem", imem_addr, 32'd0);

        // ---- redirect during BOOT is latched
        reset = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("boot_redir_imem", imem_addr, 32'h40);
        check("boot_redir_no_valid", 32'(out_valid), 32'd0);
        check("boot_flags_cleared", {30'd0, misalign_err, pc_oob}, 32'd0);
        step();
        check("boot_redir_out_pc", out_pc, 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
